// File: rtl/ps2_scan_decoder.sv
// ps2_scan_decoder
//   PS/2 keyboard receiver. It synchronises and de-glitches the raw PS/2
//   clock and data pins, deserialises 11-bit device-to-host frames, and turns
//   make/break/extended byte sequences into key events.
//
// Parameters
//   FILTER_CYCLES  : consecutive equal samples needed before the filtered
//                    PS/2 clock accepts a level change
//   TIMEOUT_CYCLES : clk cycles without a sample strobe, mid-frame, before
//                    the partial frame is dropped
//
// Ports
//   clk            : system clock
//   reset_n        : asynchronous active-low reset
//   ps2_clk_async  : raw PS/2 clock pin
//   ps2_data_async : raw PS/2 data pin
//   scan_code      : last completed make code (prefix bytes excluded)
//   ascii_code     : ASCII for scan_code, 0x00 when unmapped or extended
//   key_pressed    : high while the key in scan_code is held
//   key_released   : one-cycle pulse per completed break sequence
//
// Optional feature (macro PS2_SHIFT_EN)
//   When defined, left/right shift (0x12/0x59) are tracked as modifier state
//   rather than reported as keys, and held shift selects the shifted US
//   character set. When undefined, every key uses the unshifted table.
module ps2_scan_decoder #(
  parameter int FILTER_CYCLES  = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2_clk_async,
  input  logic       ps2_data_async,
  output logic [7:0] scan_code,
  output logic [7:0] ascii_code,
  output logic       key_pressed,
  output logic       key_released
);

  localparam int FW = $clog2(FILTER_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;

  rx_state_t       state, state_next;
  logic [1:0]      clk_sync, data_sync;
  logic            filt_clk;
  logic [FW-1:0]   filt_cnt;
  logic            strobe;
  logic            rx_bit;
  logic [2:0]      bit_cnt;
  logic [7:0]      shift_reg;
  logic            parity_bit;
  logic [TW-1:0]   to_cnt;
  logic            timed_out;
  logic            byte_ok;
  logic            brk, ext;
  logic [7:0]      key_ascii;

  // Unshifted US layout; anything not listed has no ASCII meaning.
  function automatic logic [7:0] base_ascii(input logic [7:0] code);
    case (code)
      8'h1C: return 8'h61; 8'h32: return 8'h62; 8'h21: return 8'h63;
      8'h23: return 8'h64; 8'h24: return 8'h65; 8'h2B: return 8'h66;
      8'h34: return 8'h67; 8'h33: return 8'h68; 8'h43: return 8'h69;
      8'h3B: return 8'h6A; 8'h42: return 8'h6B; 8'h4B: return 8'h6C;
      8'h3A: return 8'h6D; 8'h31: return 8'h6E; 8'h44: return 8'h6F;
      8'h4D: return 8'h70; 8'h15: return 8'h71; 8'h2D: return 8'h72;
      8'h1B: return 8'h73; 8'h2C: return 8'h74; 8'h3C: return 8'h75;
      8'h2A: return 8'h76; 8'h1D: return 8'h77; 8'h22: return 8'h78;
      8'h35: return 8'h79; 8'h1A: return 8'h7A;
      8'h45: return 8'h30; 8'h16: return 8'h31; 8'h1E: return 8'h32;
      8'h26: return 8'h33; 8'h25: return 8'h34; 8'h2E: return 8'h35;
      8'h36: return 8'h36; 8'h3D: return 8'h37; 8'h3E: return 8'h38;
      8'h46: return 8'h39;
      8'h29: return 8'h20; 8'h5A: return 8'h0D; 8'h66: return 8'h08;
      8'h0D: return 8'h09; 8'h76: return 8'h1B;
      8'h4E: return 8'h2D; 8'h55: return 8'h3D; 8'h41: return 8'h2C;
      8'h49: return 8'h2E; 8'h4A: return 8'h2F; 8'h4C: return 8'h3B;
      8'h52: return 8'h27; 8'h54: return 8'h5B; 8'h5B: return 8'h5D;
      8'h5D: return 8'h5C; 8'h0E: return 8'h60;
      default: return 8'h00;
    endcase
  endfunction

`ifdef PS2_SHIFT_EN
  logic lshift, rshift;

  // Maps an unshifted character to its shifted US counterpart; characters
  // without a shifted form (space, enter, ...) pass through.
  function automatic logic [7:0] shifted_ascii(input logic [7:0] c);
    if (c >= 8'h61 && c <= 8'h7A) return c - 8'h20;
    case (c)
      8'h31: return 8'h21; 8'h32: return 8'h40; 8'h33: return 8'h23;
      8'h34: return 8'h24; 8'h35: return 8'h25; 8'h36: return 8'h5E;
      8'h37: return 8'h26; 8'h38: return 8'h2A; 8'h39: return 8'h28;
      8'h30: return 8'h29;
      8'h2D: return 8'h5F; 8'h3D: return 8'h2B; 8'h2C: return 8'h3C;
      8'h2E: return 8'h3E; 8'h2F: return 8'h3F; 8'h3B: return 8'h3A;
      8'h27: return 8'h22; 8'h5B: return 8'h7B; 8'h5D: return 8'h7D;
      8'h5C: return 8'h7C; 8'h60: return 8'h7E;
      default: return c;
    endcase
  endfunction

  assign key_ascii = (lshift || rshift) ? shifted_ascii(base_ascii(shift_reg))
                                        : base_ascii(shift_reg);
`else
  assign key_ascii = base_ascii(shift_reg);
`endif

  // Two-flop synchronisers; idle PS/2 lines are high, so reset to 1 to avoid
  // a fake falling edge when reset is released.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk_async};
      data_sync <= {data_sync[0], ps2_data_async};
    end
  end

  assign rx_bit = data_sync[1];

  // Glitch filter: the filtered clock follows the synchronised clock only
  // after FILTER_CYCLES consecutive samples disagree with it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      filt_clk <= 1'b1;
      filt_cnt <= '0;
    end else if (clk_sync[1] == filt_clk) begin
      filt_cnt <= '0;
    end else if (filt_cnt == FW'(FILTER_CYCLES - 1)) begin
      filt_clk <= clk_sync[1];
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + 1'b1;
    end
  end

  // Strobe marks the cycle in which the filtered clock is about to fall.
  assign strobe = filt_clk && !clk_sync[1] && (filt_cnt == FW'(FILTER_CYCLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Frame sequencing; a byte is only reported when stop and odd parity agree.
  always_comb begin
    state_next = state;
    byte_ok    = 1'b0;
    timed_out  = (state != IDLE) && !strobe && (to_cnt == TW'(TIMEOUT_CYCLES - 1));
    case (state)
      IDLE:    if (strobe && !rx_bit) state_next = DATA;
      DATA:    if (strobe && bit_cnt == 3'd7) state_next = PARITY;
      PARITY:  if (strobe) state_next = STOP;
      STOP: begin
        if (strobe) begin
          state_next = IDLE;
          byte_ok    = rx_bit && (^{shift_reg, parity_bit});
        end
      end
      default: state_next = IDLE;
    endcase
    if (timed_out) state_next = IDLE;
  end

  // Deserialiser and inactivity counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt    <= '0;
      shift_reg  <= '0;
      parity_bit <= 1'b0;
      to_cnt     <= '0;
    end else begin
      if (state == IDLE || strobe) to_cnt <= '0;
      else                         to_cnt <= to_cnt + 1'b1;
      if (state == IDLE) begin
        bit_cnt <= '0;
      end else if (state == DATA && strobe) begin
        shift_reg <= {rx_bit, shift_reg[7:1]};
        bit_cnt   <= bit_cnt + 3'd1;
      end
      if (state == PARITY && strobe) parity_bit <= rx_bit;
    end
  end

  // Byte interpretation: prefixes only set flags, the next ordinary byte
  // consumes them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scan_code    <= '0;
      ascii_code   <= '0;
      key_pressed  <= 1'b0;
      key_released <= 1'b0;
      brk          <= 1'b0;
      ext          <= 1'b0;
`ifdef PS2_SHIFT_EN
      lshift       <= 1'b0;
      rshift       <= 1'b0;
`endif
    end else begin
      key_released <= 1'b0;
      if (byte_ok) begin
        if (shift_reg == 8'hE0) begin
          ext <= 1'b1;
        end else if (shift_reg == 8'hF0) begin
          brk <= 1'b1;
`ifdef PS2_SHIFT_EN
        end else if (shift_reg == 8'h12 || shift_reg == 8'h59) begin
          if (shift_reg == 8'h12) lshift <= !brk;
          else                    rshift <= !brk;
          brk <= 1'b0;
          ext <= 1'b0;
`endif
        end else if (brk) begin
          key_released <= 1'b1;
          if (shift_reg == scan_code) key_pressed <= 1'b0;
          brk <= 1'b0;
          ext <= 1'b0;
        end else begin
          scan_code   <= shift_reg;
          ascii_code  <= ext ? 8'h00 : key_ascii;
          key_pressed <= 1'b1;
          ext         <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// tb_ps2_scan_decoder
//   Directed bench for ps2_scan_decoder. Frames are bit-banged on the PS/2
//   pins with a 40-cycle PS/2 clock period; each scenario task drives its
//   frames and compares the outputs against hand-computed values. A monitor
//   counts key_released pulses and high cycles so pulse width can be checked.
module tb_ps2_scan_decoder;

  localparam int HALF = 20;
  localparam int TO   = 2000;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] scan_code, ascii_code;
  logic       key_pressed, key_released;

  int total = 0;
  int bad   = 0;
  int rel_pulses = 0;
  int rel_cycles = 0;
  logic rel_prev = 1'b0;

  ps2_scan_decoder #(.FILTER_CYCLES(8), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .ps2_clk_async(ps2_clk), .ps2_data_async(ps2_data),
    .scan_code(scan_code), .ascii_code(ascii_code),
    .key_pressed(key_pressed), .key_released(key_released)
  );

  always #10 clk = ~clk;

  // Counts release pulses and the cycles they stay high.
  always @(negedge clk) begin
    if (key_released) rel_cycles++;
    if (key_released && !rel_prev) rel_pulses++;
    rel_prev = key_released;
  end

  // Half of a PS/2 clock period, optionally with a 2-cycle glitch late in it.
  task automatic hold_half(input bit glitch);
    if (glitch) begin
      repeat (14) @(negedge clk);
      ps2_clk = ~ps2_clk;
      repeat (2) @(negedge clk);
      ps2_clk = ~ps2_clk;
      repeat (HALF - 16) @(negedge clk);
    end else begin
      repeat (HALF) @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit flip_par, input bit bad_stop,
                            input bit glitch, input int nbits);
    logic [10:0] f;
    f = {~bad_stop, (~^b) ^ flip_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      hold_half(glitch);
      ps2_clk = 1'b0;
      hold_half(glitch);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    repeat (2 * HALF) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b0, 1'b0, 11);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    total++; if (scan_code !== 8'h00) begin bad++; $display("[TB] FAIL reset_scan: got %h want 00", scan_code); end
    total++; if (ascii_code !== 8'h00) begin bad++; $display("[TB] FAIL reset_ascii: got %h want 00", ascii_code); end
    total++; if (key_pressed !== 1'b0) begin bad++; $display("[TB] FAIL reset_pressed: got %b want 0", key_pressed); end
    total++; if (key_released !== 1'b0) begin bad++; $display("[TB] FAIL reset_released: got %b want 0", key_released); end
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_make;
    send_byte(8'h1C);
    total++; if (scan_code !== 8'h1C) begin bad++; $display("[TB] FAIL make_scan: got %h want 1c", scan_code); end
    total++; if (ascii_code !== 8'h61) begin bad++; $display("[TB] FAIL make_ascii: got %h want 61", ascii_code); end
    total++; if (key_pressed !== 1'b1) begin bad++; $display("[TB] FAIL make_pressed: got %b want 1", key_pressed); end
    total++; if (rel_pulses !== 0) begin bad++; $display("[TB] FAIL make_released: got %0d pulses want 0", rel_pulses); end
  endtask

  task automatic test_break;
    int p0, c0;
    p0 = rel_pulses; c0 = rel_cycles;
    send_byte(8'hF0);
    total++; if (key_pressed !== 1'b1) begin bad++; $display("[TB] FAIL f0_only_pressed: got %b want 1", key_pressed); end
    send_byte(8'h1C);
    total++; if (rel_pulses - p0 !== 1) begin bad++; $display("[TB] FAIL break_pulses: got %0d want 1", rel_pulses - p0); end
    total++; if (rel_cycles - c0 !== 1) begin bad++; $display("[TB] FAIL break_width: got %0d want 1", rel_cycles - c0); end
    total++; if (key_pressed !== 1'b0) begin bad++; $display("[TB] FAIL break_pressed: got %b want 0", key_pressed); end
    total++; if (scan_code !== 8'h1C) begin bad++; $display("[TB] FAIL break_scan: got %h want 1c", scan_code); end
    send_byte(8'h1C);
    p0 = rel_pulses; c0 = rel_cycles;
    send_byte(8'hF0);
    send_byte(8'h32);
    total++; if (key_pressed !== 1'b1) begin bad++; $display("[TB] FAIL other_break_pressed: got %b want 1", key_pressed); end
    total++; if (rel_pulses - p0 !== 1) begin bad++; $display("[TB] FAIL other_break_pulses: got %0d want 1", rel_pulses - p0); end
    total++; if (rel_cycles - c0 !== 1) begin bad++; $display("[TB] FAIL other_break_width: got %0d want 1", rel_cycles - c0); end
    total++; if (scan_code !== 8'h1C) begin bad++; $display("[TB] FAIL other_break_scan: got %h want 1c", scan_code); end
  endtask

  task automatic test_frame_errors;
    send_frame(8'h1C, 1'b1, 1'b0, 1'b0, 11);
    send_frame(8'h32, 1'b1, 1'b0, 1'b0, 11);
    send_frame(8'h32, 1'b0, 1'b1, 1'b0, 11);
    total++; if (scan_code !== 8'h1C) begin bad++; $display("[TB] FAIL err_scan: got %h want 1c", scan_code); end
    total++; if (ascii_code !== 8'h61) begin bad++; $display("[TB] FAIL err_ascii: got %h want 61", ascii_code); end
    total++; if (key_pressed !== 1'b1) begin bad++; $display("[TB] FAIL err_pressed: got %b want 1", key_pressed); end
    send_byte(8'h29);
    total++; if (ascii_code !== 8'h20) begin bad++; $display("[TB] FAIL after_err_ascii: got %h want 20", ascii_code); end
    total++; if (scan_code !== 8'h29) begin bad++; $display("[TB] FAIL after_err_scan: got %h want 29", scan_code); end
  endtask

  task automatic test_timeout;
    send_frame(8'h32, 1'b0, 1'b0, 1'b0, 5);
    repeat (TO + 100) @(negedge clk);
    send_byte(8'h5A);
    total++; if (scan_code !== 8'h5A) begin bad++; $display("[TB] FAIL timeout_scan: got %h want 5a", scan_code); end
    total++; if (ascii_code !== 8'h0D) begin bad++; $display("[TB] FAIL timeout_ascii: got %h want 0d", ascii_code); end
  endtask

  task automatic test_extended;
    send_byte(8'hE0);
    total++; if (scan_code !== 8'h5A) begin bad++; $display("[TB] FAIL e0_only_scan: got %h want 5a", scan_code); end
    send_byte(8'h75);
    total++; if (scan_code !== 8'h75) begin bad++; $display("[TB] FAIL ext_scan: got %h want 75", scan_code); end
    total++; if (ascii_code !== 8'h00) begin bad++; $display("[TB] FAIL ext_ascii: got %h want 00", ascii_code); end
    total++; if (key_pressed !== 1'b1) begin bad++; $display("[TB] FAIL ext_pressed: got %b want 1", key_pressed); end
    send_byte(8'h1C);
    total++; if (ascii_code !== 8'h61) begin bad++; $display("[TB] FAIL ext_cleared_ascii: got %h want 61", ascii_code); end
  endtask

  task automatic test_reset_midframe;
    send_frame(8'h32, 1'b0, 1'b0, 1'b0, 5);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    total++; if (scan_code !== 8'h00) begin bad++; $display("[TB] FAIL midrst_scan: got %h want 00", scan_code); end
    total++; if (ascii_code !== 8'h00) begin bad++; $display("[TB] FAIL midrst_ascii: got %h want 00", ascii_code); end
    total++; if (key_pressed !== 1'b0) begin bad++; $display("[TB] FAIL midrst_pressed: got %b want 0", key_pressed); end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    send_byte(8'h16);
    total++; if (ascii_code !== 8'h31) begin bad++; $display("[TB] FAIL midrst_next_ascii: got %h want 31", ascii_code); end
    total++; if (scan_code !== 8'h16) begin bad++; $display("[TB] FAIL midrst_next_scan: got %h want 16", scan_code); end
  endtask

  task automatic test_glitch;
    send_frame(8'h24, 1'b0, 1'b0, 1'b1, 11);
    total++; if (scan_code !== 8'h24) begin bad++; $display("[TB] FAIL glitch_scan: got %h want 24", scan_code); end
    total++; if (ascii_code !== 8'h65) begin bad++; $display("[TB] FAIL glitch_ascii: got %h want 65", ascii_code); end
  endtask

`ifdef PS2_SHIFT_EN
  task automatic test_shift;
    int p0;
    send_byte(8'h12);
    total++; if (scan_code !== 8'h24) begin bad++; $display("[TB] FAIL shift_make_scan: got %h want 24", scan_code); end
    send_byte(8'h1C);
    total++; if (ascii_code !== 8'h41) begin bad++; $display("[TB] FAIL shift_upper: got %h want 41", ascii_code); end
    send_byte(8'h16);
    total++; if (ascii_code !== 8'h21) begin bad++; $display("[TB] FAIL shift_digit: got %h want 21", ascii_code); end
    p0 = rel_pulses;
    send_byte(8'hF0);
    send_byte(8'h12);
    total++; if (rel_pulses - p0 !== 0) begin bad++; $display("[TB] FAIL shift_break_pulses: got %0d want 0", rel_pulses - p0); end
    send_byte(8'h1C);
    total++; if (ascii_code !== 8'h61) begin bad++; $display("[TB] FAIL shift_released_lower: got %h want 61", ascii_code); end
  endtask
`else
  task automatic test_shift;
    send_byte(8'h12);
    total++; if (scan_code !== 8'h12) begin bad++; $display("[TB] FAIL plain_shift_scan: got %h want 12", scan_code); end
    total++; if (ascii_code !== 8'h00) begin bad++; $display("[TB] FAIL plain_shift_ascii: got %h want 00", ascii_code); end
    send_byte(8'h4A);
    total++; if (ascii_code !== 8'h2F) begin bad++; $display("[TB] FAIL plain_slash_ascii: got %h want 2f", ascii_code); end
    total++; if (key_pressed !== 1'b1) begin bad++; $display("[TB] FAIL plain_slash_pressed: got %b want 1", key_pressed); end
  endtask
`endif

  initial begin
    $display("[TB] starting ps2_scan_decoder bench");
    test_reset();
    test_make();
    test_break();
    test_frame_errors();
    test_timeout();
    test_extended();
    test_reset_midframe();
    test_glitch();
    test_shift();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
